// File: rtl/multi_cycle_mem_responder.sv
// Word memory that answers one request at a time with a fixed latency (accept edge to ready = LATENCY edges).
// Flags misaligned or out-of-range addresses. Requests are ignored while busy, so the CPU holds req until it sees ready.
module multi_cycle_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic        o_ready,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_busy
);

  localparam int         DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [31:0]           r_mem [DEPTH];
  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_err;
  logic [31:0]           r_rdata;

  logic                  w_accept;
  logic                  w_done;
  logic                  w_bad;
  logic [ADDR_WIDTH-1:0] w_idx;

  assign w_accept = i_req && ((r_state == ST_IDLE) || (r_state == ST_RESP));
  assign w_done   = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  // Any set bit above the word index is out of range; checking it keeps such writes from aliasing.
  assign w_bad    = (r_addr[1:0] != 2'b00) || ((r_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign w_idx    = r_addr[ADDR_WIDTH+1:2];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) r_state <= ST_WAIT;
        ST_WAIT: if (w_done) r_state <= ST_RESP;
        ST_RESP: r_state <= w_accept ? ST_WAIT : ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      if (w_accept) begin
        r_cnt   <= LAT_M1;
        r_we    <= i_we;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_wstrb <= i_wstrb;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_done) begin
        r_err <= w_bad;
        if (w_bad) begin
          r_rdata <= 32'd0;
        end else if (!r_we) begin
          r_rdata <= r_mem[w_idx];
        end
      end
    end
  end

  // Storage is intentionally unreset; a reset during WAIT forces IDLE, so no commit can follow it.
  always_ff @(posedge i_clk) begin
    if (w_done && r_we && !w_bad) begin
      for (int b = 0; b < 4; b++) begin
        if (r_wstrb[b]) r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  assign o_ready = (r_state == ST_RESP);
  assign o_busy  = (r_state == ST_WAIT);
  assign o_err   = o_ready && r_err;
  assign o_rdata = r_rdata;

endmodule

// File: doc/multi_cycle_mem_responder.md
# multi_cycle_mem_responder

Word-organised memory responder on the request/ready bus issued by the multi-cycle CPU's fetch and load/store states. It accepts one request at a time and services it after a fixed, parameterised latency, returning read data or committing a byte-masked write. It also flags misaligned or out-of-range accesses. It replaces the CPU's zero-wait memory, so that wait-state handling in the CPU control FSM can be exercised in simulation.

## Interface
- ADDR_WIDTH, 8, word-address bits; depth = 2^ADDR_WIDTH 32-bit words
- LATENCY, 2, cycles from accept edge to response (legal 1..15)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- req  input  1  request strobe from CPU
- we  input  1  1 = write, 0 = read
- addr  input  32  byte address
- wdata  input  32  write data
- wstrb  input  4  byte enables; bit i covers wdata[8i+7:8i]
- ready  output  1  one-cycle response pulse
- rdata  output  32  read data, valid while ready=1, held until next response
- err  output  1  response is an error; valid only with ready=1
- busy  output  1  request in flight; new req ignored

## Operation
- FSM states: IDLE, WAIT, RESP.
- Accept condition: req=1 at a rising edge while state is IDLE or RESP.
  - On accept: register we, addr, wdata, wstrb.
  - Load the counter with LATENCY-1.
  - Go to WAIT.
- WAIT:
  - Counter decrements each edge.
  - On the edge where the counter is 0, go to RESP and drive ready=1 for that cycle.
- RESP lasts exactly one cycle. Next state is WAIT if a request is accepted at that edge, otherwise IDLE.
- req while in WAIT is ignored. The CPU must hold req until it sees ready.
- Error detection: err=1 if addr[1:0]!=0 or addr[31:ADDR_WIDTH+2]!=0. On error:
  - No write commits.
  - rdata=0.
- Read, no error: rdata = mem[addr[ADDR_WIDTH+1:2]], sampled at the edge entering RESP.
- Write, no error:
  - Bytes with wstrb=1 are written at the edge entering RESP. Other bytes are unchanged.
  - rdata keeps its previous value.
  - wstrb=0 completes normally with no change.
- Memory array is not reset; contents are X until written.
- busy = (state==WAIT).

## Timing
- Reset (rst=0, asynchronous, no clock needed):
  - state=IDLE, counter=0.
  - ready=0, err=0, rdata=0, busy=0.
- Latency: accept at edge A puts ready=1 in the cycle after edge A+LATENCY. LATENCY=1 gives ready one cycle after the accept cycle.
- Back-to-back: req held high through the RESP cycle is accepted at the edge ending RESP. Throughput is one transaction per LATENCY+1 cycles.
- Read-after-write to the same word in back-to-back transactions returns the newly written data, since the write commits before the next read samples.
- Reset during WAIT:
  - Pending transaction is dropped and no write commits.
  - Outputs return to reset values immediately.
- Reset released mid-cycle: first possible accept is the next rising edge with rst=1.
- Out-of-range writes never alias into valid words.

## Test plan
- Reset, default params: rst=0 at t=0, released after 2 edges, req=0 -> ready=0, err=0, rdata=0, busy=0 throughout.
- Write/read: write 0xDEADBEEF to 0x10 with wstrb=4'hF, then read 0x10 -> ready exactly 2 edges after each accept, rdata=0xDEADBEEF, err=0.
- Byte mask:
  - Write 0x11223344 to 0x20 with wstrb=4'hF.
  - Write 0xAABBCCDD to 0x20 with wstrb=4'b0101.
  - Read 0x20 -> rdata=0x11BB33DD.
- Errors:
  - Read 0x12 -> ready=1, err=1, rdata=0.
  - Write to 0x400 with ADDR_WIDTH=8 -> err=1.
  - Read 0x000 afterwards -> prior contents unchanged.
- Back-to-back with LATENCY=1 and req held high for 3 transactions -> ready pulses every 2nd cycle, busy never overlaps ready.
- Reset mid-WAIT: issue write 0xCAFEF00D to 0x04 (prior value 0x0), assert rst in the WAIT cycle, then read 0x04 -> rdata=0x0, ready deasserted immediately on rst.
